wb_fetch: RTL and testbench
===========================

WB_FETCH -- requirements
Module: wb_fetch

Interface
REQ-001 Parameters (name, default, meaning): AW, 16, Wishbone word-address width; DEPTH, 4, prefetch FIFO entries (power of 2, >=2); RESET_ADDR, 0, first fetch address after reset.
REQ-002 clk  input  1  single clock; all logic on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 wb_cyc  output  1  Wishbone bus cycle.
REQ-005 wb_stb  output  1  Wishbone strobe, classic pipelined.
REQ-006 wb_we  output  1  constant 0 (read-only master).
REQ-007 wb_adr  output  AW  word address of current request.
REQ-008 wb_dat_i  input  16  read data, valid with wb_ack.
REQ-009 wb_ack  input  1  one per accepted request, in order.
REQ-010 wb_stall  input  1  slave not accepting request this cycle.
REQ-011 en  input  1  fetch enable; 0 stops new requests.
REQ-012 redirect  input  1  one-cycle pulse: flush and refetch from redirect_addr.
REQ-013 redirect_addr  input  AW  new fetch address.
REQ-014 q_valid  output  1  FIFO head valid.
REQ-015 q_data  output  16  FIFO head data.
REQ-016 q_addr  output  AW  address the head word was fetched from.
REQ-017 q_ready  input  1  consumer pops head when q_valid & q_ready.

Function
REQ-018 Request accepted in a cycle iff wb_stb & ~wb_stall; on acceptance wb_adr increments by 1 next cycle, wrapping 2^AW-1 -> 0.
REQ-019 wb_stb and wb_adr held stable while wb_stall=1 (no change of request under stall, except redirect per REQ-025).
REQ-020 Track outstanding = accepted requests not yet acked; width $clog2(DEPTH+1); +1 on acceptance, -1 on counted ack, both same cycle -> unchanged.
REQ-021 wb_stb asserted iff en & ~rst & (fifo_count + outstanding - discard) < DEPTH, evaluated from registered state (credit scheme: FIFO never overflows, ack never dropped for lack of space).
REQ-022 wb_cyc = wb_stb | (outstanding != 0); wb_cyc deasserts only when no request pending and none outstanding.
REQ-023 On wb_ack with discard = 0: push {wb_dat_i, address} into FIFO; address is taken from an internal per-request address tracker (issue-order), not from wb_adr.
REQ-024 Ack latency: word acked in cycle N visible at q_valid/q_data in cycle N+1 (registered FIFO, no bypass); zero-wait slave yields one word per cycle sustained.
REQ-025 redirect in cycle N: FIFO emptied, discard <= outstanding (after cycle-N acceptance/ack accounting), wb_adr <= redirect_addr, wb_stb may assert in cycle N+1 at redirect_addr even if a stalled request was pending.
REQ-026 While discard != 0, each wb_ack decrements discard and outstanding and is not pushed.
REQ-027 Simultaneous redirect and q_ready pop: flush wins, pop ignored; redirect and wb_ack same cycle: that ack counts as discarded if it belongs to pre-redirect requests.
REQ-028 Simultaneous push and pop: both performed, fifo_count unchanged; pop on empty FIFO ignored.
REQ-029 wb_ack with outstanding = 0: ignored, no counter underflow, no push.
REQ-030 en deasserted: no new wb_stb; outstanding acks still accepted and pushed; en does not flush.

Reset
REQ-031 While rst=1 at posedge: wb_cyc=0, wb_stb=0, wb_adr=RESET_ADDR, outstanding=0, discard=0, FIFO empty, q_valid=0; q_data/q_addr = 0.
REQ-032 Reset mid-transaction abandons outstanding requests; acks arriving after reset released with outstanding=0 ignored per REQ-029.
REQ-033 First request (wb_stb=1, wb_adr=RESET_ADDR) in the first cycle after rst deasserts if en=1.

Verification
REQ-034 Zero-wait slave, en=1, q_ready=1, RESET_ADDR=0x0100: q_addr sequence 0x0100,0x0101,... one per cycle, q_data matches memory, no gaps after fill.
REQ-035 q_ready=0, DEPTH=4: exactly 4 requests accepted, wb_stb then held 0, wb_cyc drops after 4th ack, FIFO full, no data lost; q_ready=1 resumes fetch at 0x0104.
REQ-036 Slave with 1 wait cycle (stall alternate cycles): wb_adr constant during stall, each address requested once, output order intact.
REQ-037 Slave ack latency 2, redirect to 0x2000 with 2 requests outstanding: those 2 acks discarded, first q_valid word has q_addr=0x2000.
REQ-038 redirect_addr=0xFFFE: q_addr sequence 0xFFFE,0xFFFF,0x0000.
REQ-039 rst asserted with 3 outstanding, stray ack after release: no q_valid, outputs at reset values, fetch restarts at RESET_ADDR.

Source files
------------

// File: rtl/wb_fetch.sv
// -----------------------------------------------------------------------------
// wb_fetch -- Wishbone (classic pipelined) instruction prefetcher
//
// Issues sequential read requests on a read-only Wishbone master port and
// queues the returned words, tagged with their fetch address, in a small FIFO.
// A credit check bounds requests in flight so the FIFO can never overflow.
// A redirect pulse flushes the FIFO and restarts fetching at a new address.
// Acks for requests issued before the redirect are dropped.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   wb_cyc/wb_stb   bus cycle / request strobe
//   wb_we           always 0
//   wb_adr          word address of the current request
//   wb_dat_i        read data, qualified by wb_ack
//   wb_ack          one ack per accepted request, in order
//   wb_stall        slave not accepting a request this cycle
//   en              fetch enable (gates new requests only)
//   redirect        one-cycle pulse: flush and refetch from redirect_addr
//   redirect_addr   new fetch address
//   q_valid/q_data  FIFO head valid / data
//   q_addr          fetch address of the head word
//   q_ready         consumer pops the head when q_valid & q_ready
// -----------------------------------------------------------------------------
module wb_fetch #(
    parameter int            AW         = 16,
    parameter int            DEPTH      = 4,
    parameter logic [AW-1:0] RESET_ADDR = '0
) (
    input  logic          clk,
    input  logic          rst,
    output logic          wb_cyc,
    output logic          wb_stb,
    output logic          wb_we,
    output logic [AW-1:0] wb_adr,
    input  logic [15:0]   wb_dat_i,
    input  logic          wb_ack,
    input  logic          wb_stall,
    input  logic          en,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_addr,
    output logic          q_valid,
    output logic [15:0]   q_data,
    output logic [AW-1:0] q_addr,
    input  logic          q_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    // Outstanding also holds requests whose acks are pending discard after a
    // redirect, so it can reach 2*DEPTH; size it for that.
    localparam int OW = $clog2(2 * DEPTH + 1);
    localparam int SW = OW + 1;

    logic [AW-1:0] r_adr;
    logic [AW-1:0] r_ack_adr;
    logic [OW-1:0] r_out;
    logic [OW-1:0] r_disc;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [15:0]   r_dat_mem [DEPTH];
    logic [AW-1:0] r_adr_mem [DEPTH];

    logic          w_accept;
    logic          w_ack_ok;
    logic          w_ack_disc;
    logic          w_push;
    logic          w_pop;
    logic [SW-1:0] w_level;
    logic [OW-1:0] w_out_nxt;
    logic [OW-1:0] w_disc_nxt;

    // Live words = queued + in flight that will actually be pushed.
    assign w_level  = SW'(r_count) + SW'(r_out) - SW'(r_disc);
    assign wb_stb   = en & ~rst & (w_level < SW'(DEPTH));
    assign wb_cyc   = wb_stb | (r_out != '0);
    assign wb_we    = 1'b0;
    assign wb_adr   = r_adr;

    assign w_accept   = wb_stb & ~wb_stall;
    // Acks with nothing outstanding (e.g. leftovers after reset) are ignored.
    assign w_ack_ok   = wb_ack & (r_out != '0);
    assign w_ack_disc = w_ack_ok & (r_disc != '0);
    // An ack in a redirect cycle belongs to a pre-redirect request: drop it.
    assign w_push     = w_ack_ok & ~w_ack_disc & ~redirect;
    assign w_pop      = q_valid & q_ready & ~redirect;

    assign w_out_nxt  = r_out + OW'(w_accept) - OW'(w_ack_ok);
    assign w_disc_nxt = redirect ? w_out_nxt : (r_disc - OW'(w_ack_disc));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_adr     <= RESET_ADDR;
            r_ack_adr <= RESET_ADDR;
            r_out     <= '0;
            r_disc    <= '0;
        end else begin
            r_out  <= w_out_nxt;
            r_disc <= w_disc_nxt;
            if (redirect) begin
                r_adr     <= redirect_addr;
                r_ack_adr <= redirect_addr;
            end else begin
                if (w_accept) begin
                    r_adr <= r_adr + AW'(1);
                end
                // Live acks return in issue order with consecutive addresses,
                // so a single running address tags each pushed word.
                if (w_push) begin
                    r_ack_adr <= r_ack_adr + AW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || redirect) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_dat_mem[r_wr_ptr] <= wb_dat_i;
            r_adr_mem[r_wr_ptr] <= r_ack_adr;
        end
    end

    // Head fields read as zero when empty so stale entries never show.
    assign q_valid = (r_count != '0);
    assign q_data  = q_valid ? r_dat_mem[r_rd_ptr] : '0;
    assign q_addr  = q_valid ? r_adr_mem[r_rd_ptr] : '0;

endmodule

// File: tb/tb_wb_fetch.sv
module tb_wb_fetch;

    localparam logic [15:0] RST_A = 16'h0100;

    logic        clk;
    logic        rst;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [15:0] wb_adr;
    logic [15:0] wb_dat_i;
    logic        wb_ack;
    logic        wb_stall;
    logic        en;
    logic        redirect;
    logic [15:0] redirect_addr;
    logic        q_valid;
    logic [15:0] q_data;
    logic [15:0] q_addr;
    logic        q_ready;

    wb_fetch #(.AW(16), .DEPTH(4), .RESET_ADDR(RST_A)) dut (
        .clk(clk), .rst(rst),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
        .wb_dat_i(wb_dat_i), .wb_ack(wb_ack), .wb_stall(wb_stall),
        .en(en), .redirect(redirect), .redirect_addr(redirect_addr),
        .q_valid(q_valid), .q_data(q_data), .q_addr(q_addr), .q_ready(q_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] adr;
        int          due;
    } req_t;

    req_t        sq[$];
    int          n_total = 0;
    int          n_bad   = 0;
    int          cyc_n   = 0;
    int          lat     = 1;
    bit          stall_alt = 0;
    int          n_acc   = 0;
    int          pops    = 0;
    logic [15:0] acc_exp;
    logic [15:0] exp_addr;
    bit          hold_pend = 0;
    logic [15:0] hold_adr;

    function automatic logic [15:0] mem_f(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock per iteration: drive slave, settle, observe, advance to next negedge.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            wb_ack   = 1'b0;
            wb_dat_i = 16'h0;
            if (sq.size() > 0 && sq[0].due <= cyc_n) begin
                wb_ack   = 1'b1;
                wb_dat_i = mem_f(sq[0].adr);
                void'(sq.pop_front());
            end
            wb_stall = stall_alt && (cyc_n % 2 == 1);
            #1;
            if (hold_pend && en && !rst) begin
                check("stall_hold_adr", wb_adr, hold_adr);
                check("stall_hold_stb", wb_stb, 1);
            end
            hold_pend = wb_stb && wb_stall && !redirect;
            hold_adr  = wb_adr;
            if (wb_stb && !wb_stall) begin
                check("accept_adr", wb_adr, acc_exp);
                acc_exp = acc_exp + 16'h1;
                n_acc++;
                sq.push_back('{adr: wb_adr, due: cyc_n + lat});
            end
            if (q_valid && q_ready && !redirect) begin
                check("pop_adr", q_addr, exp_addr);
                check("pop_dat", q_data, mem_f(exp_addr));
                exp_addr = exp_addr + 16'h1;
                pops++;
            end
            @(negedge clk);
            cyc_n++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sq.delete();
        hold_pend = 0;
        run(2);
        check("rst_cyc", wb_cyc, 0);
        check("rst_stb", wb_stb, 0);
        check("rst_adr", wb_adr, RST_A);
        check("rst_qvalid", q_valid, 0);
        check("rst_qdata", q_data, 0);
        check("rst_qaddr", q_addr, 0);
        rst      = 1'b0;
        acc_exp  = RST_A;
        exp_addr = RST_A;
        n_acc    = 0;
        pops     = 0;
    endtask

    task automatic do_redirect(input logic [15:0] a);
        redirect      = 1'b1;
        redirect_addr = a;
        run(1);
        redirect = 1'b0;
        acc_exp  = a;
        exp_addr = a;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; redirect = 1'b0; redirect_addr = 16'h0;
        q_ready = 1'b0; wb_ack = 1'b0; wb_dat_i = 16'h0; wb_stall = 1'b0;
        acc_exp = RST_A; exp_addr = RST_A; hold_adr = 16'h0;

        // Zero-wait slave: first request right after reset, then one word per cycle
        en = 1'b1; q_ready = 1'b1; lat = 1;
        do_reset();
        #1;
        check("first_stb", wb_stb, 1);
        check("first_adr", wb_adr, RST_A);
        run(5);
        pops = 0;
        run(10);
        check("sustain_pops", pops, 10);
        // en low: in-flight word still delivered, then bus goes idle
        en = 1'b0;
        run(5);
        check("en_off_cyc", wb_cyc, 0);
        check("en_off_qvalid", q_valid, 0);

        // Consumer stalled: exactly DEPTH requests, FIFO full, bus idle
        en = 1'b1; q_ready = 1'b0;
        do_reset();
        run(10);
        check("full_nacc", n_acc, 4);
        check("full_stb", wb_stb, 0);
        check("full_cyc", wb_cyc, 0);
        check("full_qvalid", q_valid, 1);
        check("full_qaddr", q_addr, RST_A);
        check("full_next_adr", wb_adr, 16'h0104);
        q_ready = 1'b1;
        run(12);
        check("resume_pops", pops, 12);

        // Alternate-cycle stall
        stall_alt = 1;
        do_reset();
        run(20);
        check("stall_rate", pops >= 8, 1);
        stall_alt = 0;

        // Latency 2, redirect with 2 requests outstanding
        lat = 2;
        do_reset();
        run(8);
        do_redirect(16'h2000);
        check("redir_flush", q_valid, 0);
        check("redir_adr", wb_adr, 16'h2000);
        check("redir_stb", wb_stb, 1);
        pops = 0;
        run(3);
        check("redir_nopops", pops, 0);
        check("redir_qvalid", q_valid, 1);
        check("redir_qaddr", q_addr, 16'h2000);
        run(6);

        // Address wrap after redirect near the top
        lat = 1;
        do_reset();
        run(3);
        do_redirect(16'hFFFE);
        pops = 0;
        run(8);
        check("wrap_pops", pops >= 3, 1);

        // Reset with 3 outstanding, stray acks afterwards
        lat = 4; q_ready = 1'b0;
        do_reset();
        run(3);
        check("pre_rst_nacc", n_acc, 3);
        en = 1'b0; rst = 1'b1;
        acc_exp = RST_A;
        run(1);
        rst = 1'b0;
        run(6);
        check("stray_qvalid", q_valid, 0);
        check("stray_cyc", wb_cyc, 0);
        check("stray_adr", wb_adr, RST_A);
        check("stray_qdata", q_data, 0);
        check("stray_qaddr", q_addr, 0);
        en = 1'b1; q_ready = 1'b1; exp_addr = RST_A; pops = 0;
        #1;
        check("restart_stb", wb_stb, 1);
        check("restart_adr", wb_adr, RST_A);
        run(12);
        check("restart_pops", pops >= 5, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
